// File: rtl/game_over_screen_if.sv
// Bus between game_over_screen and its neighbours: upstream VGA stream and
// game flags in, delayed VGA stream, font ROM address and game control out.
interface game_over_screen_if;
  logic        game_over;
  logic        restart;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hsync_in;
  logic        hblnk_in;
  logic        vsync_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_pixels;
  logic [10:0] char_addr;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;
  logic        play_en;
  logic        restart_out;

  modport master (
    output game_over, restart, hcount_in, vcount_in, hsync_in, hblnk_in,
           vsync_in, vblnk_in, rgb_in, char_pixels,
    input  char_addr, hcount_out, vcount_out, hsync_out, hblnk_out,
           vsync_out, vblnk_out, rgb_out, play_en, restart_out
  );

  modport slave (
    input  game_over, restart, hcount_in, vcount_in, hsync_in, hblnk_in,
           vsync_in, vblnk_in, rgb_in, char_pixels,
    output char_addr, hcount_out, vcount_out, hsync_out, hblnk_out,
           vsync_out, vblnk_out, rgb_out, play_en, restart_out
  );
endinterface

// File: rtl/game_over_screen.sv
// Game state controller (PLAY / OVER / CLEAR) with a blinking "GAME OVER"
// banner overlaid on the VGA stream. Glyph rows come from an external font
// ROM with a one-cycle read, so the stream is delayed by two pixel clocks.
module game_over_screen #(
  parameter int          TEXT_X       = 476,
  parameter int          TEXT_Y       = 376,
  parameter int          BOX_MARGIN   = 8,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] BOX_RGB      = 12'h000,
  parameter logic [11:0] TEXT_RGB     = 12'hF00
) (
  input  logic           clk,
  input  logic           rst,
  game_over_screen_if.slave bus
);

  localparam logic [1:0] PLAY  = 2'd0;
  localparam logic [1:0] OVER  = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  localparam logic [10:0] TX0 = 11'(TEXT_X);
  localparam logic [10:0] TX1 = 11'(TEXT_X + 72);
  localparam logic [10:0] TY0 = 11'(TEXT_Y);
  localparam logic [10:0] TY1 = 11'(TEXT_Y + 16);
  localparam logic [10:0] BX0 = 11'(TEXT_X - BOX_MARGIN);
  localparam logic [10:0] BX1 = 11'(TEXT_X + 72 + BOX_MARGIN);
  localparam logic [10:0] BY0 = 11'(TEXT_Y - BOX_MARGIN);
  localparam logic [10:0] BY1 = 11'(TEXT_Y + 16 + BOX_MARGIN);

  localparam int            CW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_FRAMES - 1);

  logic [1:0]    state, state_nx;
  logic          go_pend, pend_nx;
  logic [CW-1:0] blink_cnt, cnt_nx;
  logic          visible, vis_nx;
  logic          pulse_nx;

  logic          fs;
  logic [6:0]    dx;
  logic [3:0]    dy;
  logic          in_text, in_box;
  logic [6:0]    char_code;

  logic [10:0]   s1_hcount, s1_vcount;
  logic          s1_hsync, s1_vsync, s1_hblnk, s1_vblnk;
  logic [11:0]   s1_rgb;
  logic          s1_in_text, s1_in_box;
  logic [2:0]    s1_dx;

  assign fs = (bus.hcount_in == 11'd0) && (bus.vcount_in == 11'd0);

  // Only the low bits of the offsets matter: column within the text and glyph line
  assign dx = 7'(bus.hcount_in - TX0);
  assign dy = 4'(bus.vcount_in - TY0);

  assign in_text = (bus.hcount_in >= TX0) && (bus.hcount_in < TX1) &&
                   (bus.vcount_in >= TY0) && (bus.vcount_in < TY1);
  assign in_box  = (bus.hcount_in >= BX0) && (bus.hcount_in < BX1) &&
                   (bus.vcount_in >= BY0) && (bus.vcount_in < BY1);

  // Character of "GAME OVER" under the current column
  always_comb begin
    char_code = 7'h20;
    case (dx[6:3])
      4'd0: char_code = 7'h47;
      4'd1: char_code = 7'h41;
      4'd2: char_code = 7'h4D;
      4'd3: char_code = 7'h45;
      4'd4: char_code = 7'h20;
      4'd5: char_code = 7'h4F;
      4'd6: char_code = 7'h56;
      4'd7: char_code = 7'h45;
      4'd8: char_code = 7'h52;
      default: char_code = 7'h20;
    endcase
  end

  assign bus.char_addr = rst     ? 11'd0 :
                         in_text ? {char_code, dy} : {7'h20, 4'h0};

  // Next-state logic; transitions happen only at frame start so a frame is never torn
  always_comb begin
    state_nx = state;
    pend_nx  = go_pend;
    cnt_nx   = blink_cnt;
    vis_nx   = visible;
    pulse_nx = 1'b0;
    case (state)
      PLAY: begin
        if (bus.game_over) pend_nx = 1'b1;
        if (fs && (go_pend || bus.game_over)) begin
          state_nx = OVER;
          pend_nx  = 1'b0;
          cnt_nx   = '0;
          vis_nx   = 1'b1;
        end
      end
      OVER: begin
        if (bus.restart) begin
          state_nx = CLEAR;
        end else if (fs) begin
          if (blink_cnt == CNT_MAX) begin
            cnt_nx = '0;
            vis_nx = ~visible;
          end else begin
            cnt_nx = blink_cnt + 1'b1;
          end
        end
      end
      CLEAR: begin
        pend_nx = 1'b0;
        if (fs) begin
          state_nx = PLAY;
          pulse_nx = 1'b1;
        end
      end
      default: state_nx = PLAY;
    endcase
  end

  // State registers plus registered play_en / restart_out controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= PLAY;
      go_pend         <= 1'b0;
      blink_cnt       <= '0;
      visible         <= 1'b1;
      bus.play_en     <= 1'b0;
      bus.restart_out <= 1'b0;
    end else begin
      state           <= state_nx;
      go_pend         <= pend_nx;
      blink_cnt       <= cnt_nx;
      visible         <= vis_nx;
      bus.play_en     <= (state_nx == PLAY);
      bus.restart_out <= pulse_nx;
    end
  end

  // Stage 1: hold the pixel while the font ROM fetches its glyph row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hcount  <= '0;
      s1_vcount  <= '0;
      s1_hsync   <= 1'b0;
      s1_vsync   <= 1'b0;
      s1_hblnk   <= 1'b0;
      s1_vblnk   <= 1'b0;
      s1_rgb     <= '0;
      s1_in_text <= 1'b0;
      s1_in_box  <= 1'b0;
      s1_dx      <= '0;
    end else begin
      s1_hcount  <= bus.hcount_in;
      s1_vcount  <= bus.vcount_in;
      s1_hsync   <= bus.hsync_in;
      s1_vsync   <= bus.vsync_in;
      s1_hblnk   <= bus.hblnk_in;
      s1_vblnk   <= bus.vblnk_in;
      s1_rgb     <= bus.rgb_in;
      s1_in_text <= in_text;
      s1_in_box  <= in_box;
      s1_dx      <= dx[2:0];
    end
  end

  // Stage 2: glyph row is valid now, mix the banner into the output colour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.hcount_out <= '0;
      bus.vcount_out <= '0;
      bus.hsync_out  <= 1'b0;
      bus.vsync_out  <= 1'b0;
      bus.hblnk_out  <= 1'b0;
      bus.vblnk_out  <= 1'b0;
      bus.rgb_out    <= '0;
    end else begin
      bus.hcount_out <= s1_hcount;
      bus.vcount_out <= s1_vcount;
      bus.hsync_out  <= s1_hsync;
      bus.vsync_out  <= s1_vsync;
      bus.hblnk_out  <= s1_hblnk;
      bus.vblnk_out  <= s1_vblnk;
      if (s1_hblnk || s1_vblnk)
        bus.rgb_out <= 12'h000;
      else if ((state == OVER) && visible && s1_in_box)
        bus.rgb_out <= (s1_in_text && bus.char_pixels[3'd7 - s1_dx]) ? TEXT_RGB : BOX_RGB;
      else
        bus.rgb_out <= s1_rgb;
    end
  end

endmodule

// File: tb/tb_game_over_screen.sv
// Directed bench for game_over_screen: pixels are driven one at a time with
// hand-picked coordinates, frame starts are forced with a (0,0) pixel.
module tb_game_over_screen;

  logic clk;
  logic rst;
  int   totalChecks;
  int   badChecks;

  game_over_screen_if bus();

  game_over_screen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running pixel clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic setInputs(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                           input logic blank, input logic [7:0] cp);
    bus.hcount_in   = h;
    bus.vcount_in   = v;
    bus.hsync_in    = h[0];
    bus.vsync_in    = v[0];
    bus.hblnk_in    = blank;
    bus.vblnk_in    = 1'b0;
    bus.rgb_in      = rgb;
    bus.char_pixels = cp;
  endtask

  task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                               input logic blank, input logic [7:0] cp);
    setInputs(h, v, rgb, blank, cp);
    @(posedge clk);
    #1;
  endtask

  // Drive one pixel plus one filler pixel; afterwards the outputs belong to the first
  task automatic pixelOut(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                          input logic blank, input logic [7:0] cp);
    applyStimulus(h, v, rgb, blank, cp);
    applyStimulus(11'd5, 11'd5, 12'h0F0, 1'b0, cp);
  endtask

  task automatic frameStart();
    applyStimulus(11'd0, 11'd0, 12'h0F0, 1'b0, 8'h00);
  endtask

  initial begin
    totalChecks   = 0;
    badChecks     = 0;
    rst           = 1'b1;
    bus.game_over = 1'b0;
    bus.restart   = 1'b0;
    setInputs(11'd500, 11'd380, 12'h0F0, 1'b0, 8'h00);

    // 1: reset values, then plain pass-through in PLAY
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rgb", 32'(bus.rgb_out), 32'h0);
    checkOutput("rst_play_en", 32'(bus.play_en), 32'h0);
    checkOutput("rst_char_addr", 32'(bus.char_addr), 32'h0);
    checkOutput("rst_hcount", 32'(bus.hcount_out), 32'h0);
    checkOutput("rst_restart_out", 32'(bus.restart_out), 32'h0);
    rst = 1'b0;
    applyStimulus(11'd5, 11'd5, 12'h0F0, 1'b0, 8'h00);
    checkOutput("play_en_after_rst", 32'(bus.play_en), 32'h1);
    pixelOut(11'd101, 11'd100, 12'h0F0, 1'b0, 8'h00);
    checkOutput("pass_rgb", 32'(bus.rgb_out), 32'h0F0);
    checkOutput("pass_hcount", 32'(bus.hcount_out), 32'd101);
    checkOutput("pass_vcount", 32'(bus.vcount_out), 32'd100);
    checkOutput("pass_hsync", 32'(bus.hsync_out), 32'h1);
    checkOutput("pass_vsync", 32'(bus.vsync_out), 32'h0);
    pixelOut(11'd900, 11'd101, 12'h0F0, 1'b1, 8'h00);
    checkOutput("blank_rgb", 32'(bus.rgb_out), 32'h0);
    checkOutput("blank_hblnk", 32'(bus.hblnk_out), 32'h1);
    checkOutput("blank_vsync", 32'(bus.vsync_out), 32'h1);
    frameStart();
    checkOutput("play_fs_restart_out", 32'(bus.restart_out), 32'h0);
    checkOutput("play_fs_play_en", 32'(bus.play_en), 32'h1);
    pixelOut(11'd476, 11'd376, 12'h0F0, 1'b0, 8'h80);
    checkOutput("play_no_banner", 32'(bus.rgb_out), 32'h0F0);

    // Font ROM address, combinational from the current inputs
    setInputs(11'd476, 11'd379, 12'h0F0, 1'b0, 8'h00);
    #1 checkOutput("addr_G", 32'(bus.char_addr), 32'({7'h47, 4'd3}));
    setInputs(11'd500, 11'd379, 12'h0F0, 1'b0, 8'h00);
    #1 checkOutput("addr_E", 32'(bus.char_addr), 32'({7'h45, 4'd3}));
    setInputs(11'd547, 11'd391, 12'h0F0, 1'b0, 8'h00);
    #1 checkOutput("addr_R", 32'(bus.char_addr), 32'({7'h52, 4'd15}));
    setInputs(11'd400, 11'd379, 12'h0F0, 1'b0, 8'h00);
    #1 checkOutput("addr_outside", 32'(bus.char_addr), 32'({7'h20, 4'd0}));

    // 2: game_over pulse mid-frame takes effect at the next frame start
    bus.game_over = 1'b1;
    applyStimulus(11'd200, 11'd100, 12'h0F0, 1'b0, 8'h00);
    bus.game_over = 1'b0;
    checkOutput("pend_play_en", 32'(bus.play_en), 32'h1);
    applyStimulus(11'd300, 11'd500, 12'h0F0, 1'b0, 8'h00);
    checkOutput("pend_play_en_late", 32'(bus.play_en), 32'h1);
    frameStart();
    checkOutput("over_play_en", 32'(bus.play_en), 32'h0);
    pixelOut(11'd476, 11'd376, 12'h0F0, 1'b0, 8'h80);
    checkOutput("glyph_px", 32'(bus.rgb_out), 32'hF00);
    pixelOut(11'd470, 11'd376, 12'h0F0, 1'b0, 8'hFF);
    checkOutput("box_px", 32'(bus.rgb_out), 32'h000);
    pixelOut(11'd100, 11'd100, 12'h0F0, 1'b0, 8'hFF);
    checkOutput("far_px", 32'(bus.rgb_out), 32'h0F0);
    pixelOut(11'd477, 11'd376, 12'h0F0, 1'b0, 8'h80);
    checkOutput("glyph_bit_clear", 32'(bus.rgb_out), 32'h000);
    pixelOut(11'd547, 11'd391, 12'h0F0, 1'b0, 8'h01);
    checkOutput("text_last_px", 32'(bus.rgb_out), 32'hF00);
    pixelOut(11'd548, 11'd376, 12'h0F0, 1'b0, 8'hFF);
    checkOutput("right_margin", 32'(bus.rgb_out), 32'h000);
    pixelOut(11'd476, 11'd392, 12'h0F0, 1'b0, 8'hFF);
    checkOutput("bottom_margin", 32'(bus.rgb_out), 32'h000);
    pixelOut(11'd467, 11'd376, 12'h0F0, 1'b0, 8'hFF);
    checkOutput("left_outside", 32'(bus.rgb_out), 32'h0F0);
    pixelOut(11'd556, 11'd376, 12'h0F0, 1'b0, 8'hFF);
    checkOutput("right_outside", 32'(bus.rgb_out), 32'h0F0);
    pixelOut(11'd476, 11'd367, 12'h0F0, 1'b0, 8'hFF);
    checkOutput("top_outside", 32'(bus.rgb_out), 32'h0F0);
    pixelOut(11'd555, 11'd399, 12'h0F0, 1'b0, 8'hFF);
    checkOutput("box_corner", 32'(bus.rgb_out), 32'h000);
    pixelOut(11'd476, 11'd376, 12'h0F0, 1'b1, 8'hFF);
    checkOutput("banner_blank", 32'(bus.rgb_out), 32'h000);

    // 3: blink, visible for frames 0-29, hidden 30-59, visible again at 60
    for (int f = 1; f <= 61; f++) begin
      frameStart();
      pixelOut(11'd476, 11'd376, 12'h0F0, 1'b0, 8'h80);
      checkOutput($sformatf("blink_f%0d", f), 32'(bus.rgb_out),
                  ((f < 30) || (f >= 60)) ? 32'hF00 : 32'h0F0);
    end

    // 4: restart together with a frame start goes to CLEAR
    bus.restart = 1'b1;
    frameStart();
    bus.restart = 1'b0;
    checkOutput("clear_play_en", 32'(bus.play_en), 32'h0);
    checkOutput("clear_restart_out", 32'(bus.restart_out), 32'h0);
    pixelOut(11'd476, 11'd376, 12'h0F0, 1'b0, 8'h80);
    checkOutput("clear_no_banner", 32'(bus.rgb_out), 32'h0F0);
    frameStart();
    checkOutput("restart_pulse", 32'(bus.restart_out), 32'h1);
    checkOutput("restart_play_en", 32'(bus.play_en), 32'h1);
    applyStimulus(11'd5, 11'd5, 12'h0F0, 1'b0, 8'h00);
    checkOutput("restart_pulse_end", 32'(bus.restart_out), 32'h0);

    // 5: game_over held through CLEAR re-enters OVER one frame after PLAY
    bus.game_over = 1'b1;
    frameStart();
    checkOutput("reover_play_en", 32'(bus.play_en), 32'h0);
    bus.restart = 1'b1;
    applyStimulus(11'd5, 11'd5, 12'h0F0, 1'b0, 8'h00);
    bus.restart = 1'b0;
    applyStimulus(11'd6, 11'd5, 12'h0F0, 1'b0, 8'h00);
    frameStart();
    checkOutput("held_restart_pulse", 32'(bus.restart_out), 32'h1);
    checkOutput("held_play_en", 32'(bus.play_en), 32'h1);
    applyStimulus(11'd5, 11'd5, 12'h0F0, 1'b0, 8'h00);
    bus.game_over = 1'b0;
    bus.restart   = 1'b1;
    applyStimulus(11'd6, 11'd5, 12'h0F0, 1'b0, 8'h00);
    bus.restart   = 1'b0;
    checkOutput("play_restart_ignored", 32'(bus.play_en), 32'h1);
    checkOutput("play_restart_no_pulse", 32'(bus.restart_out), 32'h0);
    frameStart();
    checkOutput("pend_over_play_en", 32'(bus.play_en), 32'h0);
    pixelOut(11'd476, 11'd376, 12'h0F0, 1'b0, 8'h80);
    checkOutput("pend_over_banner", 32'(bus.rgb_out), 32'hF00);

    // 6: asynchronous reset in the middle of an OVER line
    setInputs(11'd500, 11'd380, 12'h0F0, 1'b0, 8'h80);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_rgb", 32'(bus.rgb_out), 32'h0);
    checkOutput("arst_hcount", 32'(bus.hcount_out), 32'h0);
    checkOutput("arst_vcount", 32'(bus.vcount_out), 32'h0);
    checkOutput("arst_play_en", 32'(bus.play_en), 32'h0);
    checkOutput("arst_char_addr", 32'(bus.char_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(11'd5, 11'd5, 12'h0F0, 1'b0, 8'h00);
    checkOutput("arst_release_play_en", 32'(bus.play_en), 32'h1);
    pixelOut(11'd476, 11'd376, 12'h0F0, 1'b0, 8'h80);
    checkOutput("arst_no_banner", 32'(bus.rgb_out), 32'h0F0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
